// File: rtl/loa_scan_pkg.sv
// Shared definitions for the LOA error-scan controller.
//   - scan_state_e : sequencer states
//   - err_w()      : width of the signed error word (WIDTH+2)
//   - cnt_w()      : width of the error counter (2*WIDTH+1)
// No ports; imported by loa_err_accum and loa_error_scan_ctrl.
package loa_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ERR_W = DEF_WIDTH + 2;
  localparam int DEF_CNT_W = 2 * DEF_WIDTH + 1;

  // Signed error (approx - exact) needs one extra bit beyond the WIDTH+1 sum.
  function automatic int err_w(input int width);
    return width + 2;
  endfunction

  // Must hold the count 2^(2*WIDTH) itself, not just 2^(2*WIDTH)-1.
  function automatic int cnt_w(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/loa_err_accum.sv
// Error statistics accumulator for the LOA error scan.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_clear           zero all statistics (new scan)
//   i_valid           accumulate i_err this cycle
//   i_err             signed error approx - exact, WIDTH+2 bits
//   o_err_cnt         number of non-zero errors
//   o_err_sum         signed running sum of errors
//   o_abs_sum         running sum of |err|
//   o_sq_sum          running sum of err^2 (zero unless LOA_SCAN_SQERR_EN)
//   o_max_abs_err     largest |err| seen
// Build option: LOA_SCAN_SQERR_EN adds the squarer and sq_sum accumulator.
module loa_err_accum
  import loa_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 48
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clear,
  input  logic                      i_valid,
  input  logic [WIDTH+1:0]          i_err,
  output logic [2*WIDTH:0]          o_err_cnt,
  output logic [ACC_W-1:0]          o_err_sum,
  output logic [ACC_W-1:0]          o_abs_sum,
  output logic [ACC_W-1:0]          o_sq_sum,
  output logic [WIDTH+1:0]          o_max_abs_err
);

  localparam int ERR_W = err_w(WIDTH);
  localparam int CNT_W = cnt_w(WIDTH);

  logic [ERR_W-1:0] w_abs;
  logic [ACC_W-1:0] w_err_ext;
  logic [ACC_W-1:0] w_abs_ext;

  logic [CNT_W-1:0] r_err_cnt;
  logic [ACC_W-1:0] r_err_sum;
  logic [ACC_W-1:0] r_abs_sum;
  logic [ERR_W-1:0] r_max_abs;

  // The most negative ERR_W value is unreachable (|err| <= 2^(WIDTH+1)-1),
  // so negation never overflows.
  assign w_abs     = i_err[ERR_W-1] ? (~i_err + ERR_W'(1)) : i_err;
  assign w_err_ext = {{(ACC_W-ERR_W){i_err[ERR_W-1]}}, i_err};
  assign w_abs_ext = {{(ACC_W-ERR_W){1'b0}}, w_abs};

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_err_cnt <= '0;
      r_err_sum <= '0;
      r_abs_sum <= '0;
      r_max_abs <= '0;
    end else if (i_valid) begin
      if (i_err != '0) r_err_cnt <= r_err_cnt + CNT_W'(1);
      r_err_sum <= r_err_sum + w_err_ext;
      r_abs_sum <= r_abs_sum + w_abs_ext;
      if (w_abs > r_max_abs) r_max_abs <= w_abs;
    end
  end

`ifdef LOA_SCAN_SQERR_EN
  logic [2*ERR_W-1:0] w_sq;
  logic [ACC_W-1:0]   r_sq_sum;

  // err^2 == |err|^2, so an unsigned squarer suffices.
  assign w_sq = {{ERR_W{1'b0}}, w_abs} * {{ERR_W{1'b0}}, w_abs};

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_sq_sum <= '0;
    end else if (i_valid) begin
      r_sq_sum <= r_sq_sum + {{(ACC_W-2*ERR_W){1'b0}}, w_sq};
    end
  end

  assign o_sq_sum = r_sq_sum;
`else
  assign o_sq_sum = '0;
`endif

  assign o_err_cnt     = r_err_cnt;
  assign o_err_sum     = r_err_sum;
  assign o_abs_sum     = r_abs_sum;
  assign o_max_abs_err = r_max_abs;

endmodule

// File: rtl/loa_error_scan_ctrl.sv
// Sequencer that sweeps all operand pairs of an external approximate adder
// and accumulates error statistics against the exact sum.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a scan (honoured in IDLE or DONE only)
//   pause             freeze the scan while high in RUN
//   a_out, b_out      registered operands to the adder under test
//   approx_sum        adder result for the current a_out/b_out
//   busy              high while scanning
//   done              one-cycle pulse when the last pair is accumulated
//   err_cnt, err_sum, abs_sum, sq_sum, max_abs_err   scan statistics
// Build option: LOA_SCAN_SQERR_EN enables sq_sum (otherwise tied to 0).
module loa_error_scan_ctrl
  import loa_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pause,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  input  logic [WIDTH:0]       approx_sum,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH:0]     err_cnt,
  output logic [ACC_W-1:0]     err_sum,
  output logic [ACC_W-1:0]     abs_sum,
  output logic [ACC_W-1:0]     sq_sum,
  output logic [WIDTH+1:0]     max_abs_err
);

  localparam int ERR_W = err_w(WIDTH);

  scan_state_e      r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_busy;
  logic             r_done;

  logic [ERR_W-1:0] w_exact;
  logic [ERR_W-1:0] w_err;
  logic             w_start_ok;
  logic             w_step;
  logic             w_last;

  assign w_exact    = {2'b00, r_a} + {2'b00, r_b};
  assign w_err      = {1'b0, approx_sum} - w_exact;
  assign w_start_ok = start && (r_state != RUN);
  assign w_step     = (r_state == RUN) && !pause;
  assign w_last     = (&r_a) && (&r_b);

  // NOTE: non-blocking assignments throughout, so every register in this
  // block sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a     <= '0;
            r_b     <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!pause) begin
            // b innermost; the all-ones pair wraps both operands back to 0.
            {r_a, r_b} <= {r_a, r_b} + (2*WIDTH)'(1);
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  loa_err_accum #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_accum (
    .clk           (clk),
    .rst           (rst),
    .i_clear       (w_start_ok),
    .i_valid       (w_step),
    .i_err         (w_err),
    .o_err_cnt     (err_cnt),
    .o_err_sum     (err_sum),
    .o_abs_sum     (abs_sum),
    .o_sq_sum      (sq_sum),
    .o_max_abs_err (max_abs_err)
  );

  assign a_out = r_a;
  assign b_out = r_b;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_loa_error_scan_ctrl.sv
// Scoreboard bench for loa_error_scan_ctrl at WIDTH=4 (256 pairs per scan).
// The stimulus pushes the hand-computed result of each scan when it issues
// start; a monitor pops and compares whenever done pulses.
module tb_loa_error_scan_ctrl;

  localparam int W     = 4;
  localparam int ACC_W = 48;
  localparam int N     = 1 << (2 * W);
  localparam int CNTW  = 2 * W + 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic             pause;
  logic [W-1:0]     a_out;
  logic [W-1:0]     b_out;
  logic [W:0]       approx_sum;
  logic             busy;
  logic             done;
  logic [CNTW-1:0]  err_cnt;
  logic [ACC_W-1:0] err_sum;
  logic [ACC_W-1:0] abs_sum;
  logic [ACC_W-1:0] sq_sum;
  logic [W+1:0]     max_abs_err;

  loa_error_scan_ctrl #(.WIDTH(W), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pause       (pause),
    .a_out       (a_out),
    .b_out       (b_out),
    .approx_sum  (approx_sum),
    .busy        (busy),
    .done        (done),
    .err_cnt     (err_cnt),
    .err_sum     (err_sum),
    .abs_sum     (abs_sum),
    .sq_sum      (sq_sum),
    .max_abs_err (max_abs_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder-under-test stub, selected by mode.
  int mode = 0;
  always_comb begin
    approx_sum = {1'b0, a_out} + {1'b0, b_out};
    case (mode)
      1: approx_sum = {1'b0, a_out} + {1'b0, b_out} + (W+1)'(1);
      2: if (a_out == '0 && b_out == W'(1)) approx_sum = '0;
      3: approx_sum = {({1'b0, a_out[W-1:1]} + {1'b0, b_out[W-1:1]}), a_out[0] | b_out[0]};
      4: approx_sum = '0;
      5: approx_sum = '1;
      default: ;
    endcase
  end

  typedef struct {
    string            name;
    logic [CNTW-1:0]  cnt;
    logic [ACC_W-1:0] esum;
    logic [ACC_W-1:0] asum;
    logic [ACC_W-1:0] sq;
    logic [W+1:0]     maxe;
    int               lat;
    int               start_cyc;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [ACC_W-1:0] sq_exp(input longint v);
`ifdef LOA_SCAN_SQERR_EN
    return ACC_W'(v);
`else
    return '0;
`endif
  endfunction

  // Monitor: compare on every done pulse, then confirm the pulse is one cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 expected no scan in flight");
        end else begin
          e = q.pop_front();
          check({e.name, ".err_cnt"},     64'(err_cnt),         64'(e.cnt));
          check({e.name, ".err_sum"},     64'(err_sum),         64'(e.esum));
          check({e.name, ".abs_sum"},     64'(abs_sum),         64'(e.asum));
          check({e.name, ".sq_sum"},      64'(sq_sum),          64'(e.sq));
          check({e.name, ".max_abs_err"}, 64'(max_abs_err),     64'(e.maxe));
          check({e.name, ".latency"},     64'(cyc - e.start_cyc), 64'(e.lat));
          @(negedge clk);
          check({e.name, ".done_width"},  64'(done), 64'(0));
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, ".busy"},        64'(busy),        64'(0));
    check({tag, ".done"},        64'(done),        64'(0));
    check({tag, ".a_out"},       64'(a_out),       64'(0));
    check({tag, ".b_out"},       64'(b_out),       64'(0));
    check({tag, ".err_cnt"},     64'(err_cnt),     64'(0));
    check({tag, ".err_sum"},     64'(err_sum),     64'(0));
    check({tag, ".abs_sum"},     64'(abs_sum),     64'(0));
    check({tag, ".sq_sum"},      64'(sq_sum),      64'(0));
    check({tag, ".max_abs_err"}, 64'(max_abs_err), 64'(0));
  endtask

  // One complete scan. Edges k=pause_at+1..pause_at+pause_len are paused
  // (pause_at=0 also raises pause on the start edge, where start must win).
  // poke_at>0 pulses start on edge poke_at while running.
  task automatic scan(input string nm, input int md, input int cnt, input longint esum,
                      input longint asum, input longint sq, input int maxe,
                      input int pause_at, input int pause_len, input int poke_at);
    exp_t e;
    logic [W-1:0] snap_a, snap_b;
    bit finished;
    mode = md;
    snap_a = '0;
    snap_b = '0;
    @(negedge clk);
    start = 1'b1;
    pause = (pause_at == 0 && pause_len > 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    e.name = nm; e.cnt = CNTW'(cnt); e.esum = ACC_W'(esum); e.asum = ACC_W'(asum);
    e.sq = sq_exp(sq); e.maxe = (W+2)'(maxe); e.lat = N + pause_len; e.start_cyc = cyc;
    q.push_back(e);
    finished = 1'b0;
    for (int k = 1; k <= N + pause_len + 20; k++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) begin
        finished = 1'b1;
        break;
      end
      if (pause_len > 0 && k == pause_at + 1) begin
        snap_a = a_out;
        snap_b = b_out;
      end
      if (pause_len > 0 && k == pause_at + pause_len + 1) begin
        check({nm, ".pause_hold_a"}, 64'(a_out), 64'(snap_a));
        check({nm, ".pause_hold_b"}, 64'(b_out), 64'(snap_b));
        check({nm, ".pause_busy"},   64'(busy),  64'(1));
      end
      pause = (pause_len > 0) && (k >= pause_at + 1) && (k <= pause_at + pause_len);
      start = (poke_at > 0) && (k == poke_at);
    end
    pause = 1'b0;
    start = 1'b0;
    if (!finished) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s.timeout: got no done within %0d cycles expected done", nm, N + pause_len + 20);
      q.delete();
    end
    repeat (3) @(negedge clk);
    check({nm, ".hold_err_cnt"}, 64'(err_cnt), 64'(e.cnt));
    check({nm, ".hold_abs_sum"}, 64'(abs_sum), 64'(e.asum));
    check({nm, ".idle_a_out"},   64'(a_out),   64'(0));
    check({nm, ".idle_b_out"},   64'(b_out),   64'(0));
    check({nm, ".idle_busy"},    64'(busy),    64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle");

    // name, mode, err_cnt, err_sum, abs_sum, sq_sum, max, pause_at, pause_len, poke_at
    scan("exact",   0,   0,     0,    0,     0,  0,  0,   0,  0);
    scan("plus1",   1, 256,   256,  256,   256,  1,  0,   0,  0);
    scan("minus1",  2,   1,    -1,    1,     1,  1,  0,   0,  0);
    // LOA low bit: err=-1 exactly when a[0]&b[0] (64 pairs); 100-cycle pause.
    scan("loa1",    3,  64,   -64,   64,    64,  1, 50, 100,  0);
    // approx=0: err=-(a+b); sum(a+b)=3840, sum(a+b)^2=68480; start poke ignored.
    scan("zero",    4, 255, -3840, 3840, 68480, 30,  0,   0, 30);
    // approx=31: err=31-(a+b); start and pause together, then 10 paused edges.
    scan("ones",    5, 256,  4096, 4096, 76416, 31,  0,  10,  0);

    // Reset in the middle of a scan, then a clean full scan.
    mode = 5;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    check("midscan.busy", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check_zero("midscan_rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    scan("after_rst", 5, 256, 4096, 4096, 76416, 31, 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
